// File: rtl/alu_bist_misr.sv
// BIST controller for the datapath ALU: two LFSRs supply operands, every alu_sel code is swept
// per operand pair, and a MISR compacts {alu_out, alu_carry} into one signature compared at the end.
module alu_bist_misr #(
  parameter int                WIDTH        = 8,
  parameter int                NUM_PATTERNS = 256,
  parameter logic [WIDTH-1:0]  SEED_A       = 8'h02,
  parameter logic [WIDTH-1:0]  SEED_B       = 8'h01,
  parameter logic [WIDTH-1:0]  LFSR_TAPS    = 8'hB8,
  parameter logic [WIDTH:0]    MISR_TAPS    = 9'h110,
  parameter logic [WIDTH:0]    GOLDEN_SIG   = 9'h000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   signature,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(NUM_PATTERNS + 1);
  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SEED_A_EFF = (SEED_A == '0) ? ONE : SEED_A;
  localparam logic [WIDTH-1:0] SEED_B_EFF = (SEED_B == '0) ? ONE : SEED_B;
  localparam logic [CW-1:0]    LAST_PAT   = CW'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   pat_cnt;
  logic [WIDTH:0]  misr_next;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & LFSR_TAPS)};
  endfunction

  always_comb begin
    misr_next = {signature[WIDTH-1:0], ^(signature & MISR_TAPS)} ^ {alu_out, alu_carry};
  end

  // Command semantics: start and abort are sampled at every rising edge; start acts only in
  // IDLE or DONE, abort returns to IDLE from any state and wins when both are high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      alu_a     <= SEED_A_EFF;
      alu_b     <= SEED_B_EFF;
      alu_sel   <= 4'd0;
      pat_cnt   <= '0;
      signature <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            alu_a     <= SEED_A_EFF;
            alu_b     <= SEED_B_EFF;
            alu_sel   <= 4'd0;
            pat_cnt   <= '0;
            signature <= '0;
          end
        end
        RUN: begin
          signature <= misr_next;
          alu_sel   <= alu_sel + 4'd1;
          if (alu_sel == 4'hF) begin
            // The final pair is not stepped past, so the operands stay on it in DONE.
            if (pat_cnt == LAST_PAT) begin
              state <= DONE;
            end else begin
              alu_a   <= lfsr_step(alu_a);
              alu_b   <= lfsr_step(alu_b);
              pat_cnt <= pat_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign pass      = done && (signature == GOLDEN_SIG);
  assign fsm_state = state;

endmodule

// File: tb/tb_alu_bist_misr.sv
// Bench for alu_bist_misr: behavioural ALU, table of hand-derived operand vectors, an expected
// operand queue, and whole-run signatures computed by a plain model of the LFSR/MISR rules.
module tb_alu_bist_misr;
  localparam int W = 8;
  localparam logic [W-1:0] TAPS  = 8'hB8;
  localparam logic [W:0]   MTAPS = 9'h110;

  function automatic logic [W:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] sel);
    logic [W:0]   wide;
    logic [W-1:0] y;
    logic         c;
    wide = '0;
    y    = '0;
    c    = 1'b0;
    case (sel)
      4'd0:  begin wide = {1'b0, a} + {1'b0, b}; y = wide[W-1:0]; c = wide[W]; end
      4'd1:  begin wide = {1'b0, a} - {1'b0, b}; y = wide[W-1:0]; c = wide[W]; end
      4'd2:  y = a * b;
      4'd3:  y = (b == '0) ? '0 : a / b;
      4'd4:  begin y = a << 1; c = a[W-1]; end
      4'd5:  begin y = a >> 1; c = a[0]; end
      4'd6:  y = {a[W-2:0], a[W-1]};
      4'd7:  y = {a[0], a[W-1:1]};
      4'd8:  y = a & b;
      4'd9:  y = a | b;
      4'd10: y = a ^ b;
      4'd11: y = ~(a | b);
      4'd12: y = ~(a & b);
      4'd13: y = ~(a ^ b);
      4'd14: y = {{(W-1){1'b0}}, (a > b)};
      default: y = {{(W-1){1'b0}}, (a == b)};
    endcase
    return {y, c};
  endfunction

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
    return {s[W-2:0], ^(s & TAPS)};
  endfunction

  function automatic logic [W:0] misr_next(input logic [W:0] s, input logic [W:0] d);
    return {s[W-1:0], ^(s & MTAPS)} ^ d;
  endfunction

  // Signature after a whole run; fault_cyc >= 0 flips the carry seen on that sweep cycle.
  function automatic logic [W:0] model_sig(input logic [W-1:0] sa, input logic [W-1:0] sb,
                                           input int npat, input int fault_cyc);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   s;
    logic [W:0]   d;
    a = sa;
    b = sb;
    s = '0;
    for (int p = 0; p < npat; p++) begin
      for (int k = 0; k < 16; k++) begin
        d = alu_model(a, b, 4'(k));
        if (p * 16 + k == fault_cyc) d[0] = ~d[0];
        s = misr_next(s, d);
      end
      a = lfsr_next(a);
      b = lfsr_next(b);
    end
    return s;
  endfunction

  localparam logic [W:0] GOLD_256 = model_sig(8'h02, 8'h01, 256, -1);
  localparam logic [W:0] GOLD_4   = model_sig(8'h02, 8'h01, 4, -1);
  localparam logic [W:0] GOLD_4F  = model_sig(8'h02, 8'h01, 4, 32);
  localparam logic [W:0] GOLD_1   = model_sig(8'h01, 8'h01, 1, -1);

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic start0, abort0, start1, abort1, start2, abort2, fault;
  logic [W-1:0] a0, b0, a1, b1, a2, b2;
  logic [3:0]   sel0, sel1, sel2;
  logic [W-1:0] out0, out1, out2;
  logic         c0, c1, c2;
  logic [W:0]   r1;
  logic         busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [W:0]   sig0, sig1, sig2;
  logic [1:0]   st0, st1, st2;

  assign {out0, c0} = alu_model(a0, b0, sel0);
  assign r1         = alu_model(a1, b1, sel1);
  assign out1       = r1[W:1];
  assign c1         = r1[0] ^ fault;
  assign {out2, c2} = alu_model(a2, b2, sel2);

  alu_bist_misr #(.GOLDEN_SIG(GOLD_256)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0),
    .alu_a(a0), .alu_b(b0), .alu_sel(sel0), .alu_out(out0), .alu_carry(c0),
    .busy(busy0), .done(done0), .pass(pass0), .signature(sig0), .fsm_state(st0)
  );

  alu_bist_misr #(.NUM_PATTERNS(4), .GOLDEN_SIG(GOLD_4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .alu_a(a1), .alu_b(b1), .alu_sel(sel1), .alu_out(out1), .alu_carry(c1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .fsm_state(st1)
  );

  alu_bist_misr #(.SEED_A(8'h00), .NUM_PATTERNS(1), .GOLDEN_SIG(GOLD_1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2),
    .alu_a(a2), .alu_b(b2), .alu_sel(sel2), .alu_out(out2), .alu_carry(c2),
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .fsm_state(st2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [2*W+3:0] exp_q[$];

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
  } vec_t;
  localparam int N_VEC = 9;
  vec_t vec[N_VEC];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic fill_exp(input int npat);
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_q.delete();
    a = 8'h02;
    b = 8'h01;
    for (int p = 0; p < npat; p++) begin
      for (int k = 0; k < 16; k++) exp_q.push_back({a, b, 4'(k)});
      a = lfsr_next(a);
      b = lfsr_next(b);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cmd(input int dut, input logic s, input logic ab);
    case (dut)
      0: begin start0 = s; abort0 = ab; end
      1: begin start1 = s; abort1 = ab; end
      default: begin start2 = s; abort2 = ab; end
    endcase
    @(negedge clk);
    start0 = 1'b0; abort0 = 1'b0;
    start1 = 1'b0; abort1 = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
  endtask

  // Called on the negedge of sweep cycle 0; returns on the negedge after ncyc sweep cycles.
  task automatic run0(input int ncyc, input bit noise);
    int errs;
    logic [2*W+3:0] want;
    errs = 0;
    fill_exp(256);
    check("run_start_sig", sig0, 0);
    check("run_start_done", {busy0, done0}, 2'b10);
    for (int k = 0; k < ncyc; k++) begin
      want = exp_q.pop_front();
      if ({a0, b0, sel0} !== want || busy0 !== 1'b1 || done0 !== 1'b0) errs++;
      for (int v = 0; v < N_VEC; v++)
        if (vec[v].cyc == k) check("lfsr_vec", {a0, b0, sel0}, {vec[v].a, vec[v].b, vec[v].sel});
      start0 = noise && ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    start0 = 1'b0;
    check("operand_stream", errs, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int errs;
    reset = 1'b1;
    fault = 1'b0;
    start0 = 1'b0; abort0 = 1'b0;
    start1 = 1'b0; abort1 = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
    vec[0] = '{0,   8'h02, 8'h01, 4'd0};
    vec[1] = '{15,  8'h02, 8'h01, 4'd15};
    vec[2] = '{16,  8'h04, 8'h02, 4'd0};
    vec[3] = '{40,  8'h08, 8'h04, 4'd8};
    vec[4] = '{48,  8'h11, 8'h08, 4'd0};
    vec[5] = '{79,  8'h23, 8'h11, 4'd15};
    vec[6] = '{80,  8'h47, 8'h23, 4'd0};
    vec[7] = '{100, 8'h8E, 8'h47, 4'd4};
    vec[8] = '{127, 8'h1C, 8'h8E, 4'd15};

    repeat (2) @(negedge clk);
    check("reset_ops", {a0, b0, sel0}, {8'h02, 8'h01, 4'd0});
    check("reset_flags", {busy0, done0, pass0}, 3'b000);
    check("reset_sig", sig0, 0);
    check("zero_seed_a", a2, 8'h01);
    reset = 1'b0;
    @(negedge clk);

    cmd(0, 1'b0, 1'b1);
    check("abort_in_idle", {busy0, done0, a0}, {2'b00, 8'h02});

    repeat ($urandom_range(0, 7)) @(negedge clk);
    cmd(0, 1'b1, 1'b0);
    run0(4096, 1'b0);
    check("full_done", {busy0, done0, pass0}, 3'b011);
    check("full_sig", sig0, GOLD_256);

    repeat ($urandom_range(1, 5)) @(negedge clk);
    check("done_hold", {done0, sig0}, {1'b1, GOLD_256});

    cmd(0, 1'b1, 1'b0);
    run0(4096, 1'b1);
    check("restart_done", {busy0, done0, pass0}, 3'b011);
    check("restart_sig", sig0, GOLD_256);

    cmd(0, 1'b1, 1'b1);
    check("start_abort_done", {busy0, done0, pass0}, 3'b000);
    check("abort_sig_hold", sig0, GOLD_256);

    cmd(0, 1'b1, 1'b0);
    run0(100, 1'b0);
    cmd(0, 1'b0, 1'b1);
    check("abort_mid_run", {busy0, done0, pass0}, 3'b000);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    cmd(0, 1'b1, 1'b0);
    run0(4096, 1'b0);
    check("after_abort_pass", {busy0, done0, pass0}, 3'b011);

    // NUM_PATTERNS=4: clean run then one corrupted carry on pattern 2, sel 0.
    cmd(1, 1'b1, 1'b0);
    repeat (64) @(negedge clk);
    check("np4_clean", {done1, pass1, sig1}, {2'b11, GOLD_4});
    cmd(1, 1'b1, 1'b0);
    for (int k = 0; k < 64; k++) begin
      fault = (k == 32);
      if (k == 63) check("np4_done_late", done1, 1'b0);
      @(negedge clk);
    end
    fault = 1'b0;
    check("fault_flags", {busy1, done1, pass1}, 3'b010);
    check("fault_sig", sig1, GOLD_4F);
    check("fault_sig_differs", (sig1 != GOLD_4), 1'b1);

    // NUM_PATTERNS=1 with zero seed A.
    cmd(2, 1'b1, 1'b0);
    errs = 0;
    for (int k = 0; k < 16; k++) begin
      if ({a2, b2, sel2, done2} !== {8'h01, 8'h01, 4'(k), 1'b0}) errs++;
      @(negedge clk);
    end
    check("np1_sweep", errs, 0);
    check("np1_done", {busy2, done2, pass2, sig2}, {3'b011, GOLD_1});
    check("np1_no_step", {a2, b2}, {8'h01, 8'h01});

    // Asynchronous reset in the middle of a run.
    cmd(0, 1'b1, 1'b0);
    repeat ($urandom_range(20, 300)) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_ops", {a0, b0, sel0}, {8'h02, 8'h01, 4'd0});
    check("async_reset_flags", {busy0, done0, pass0, sig0}, 12'h000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
